// File: rtl/mips_uart_loader_pkg.sv
// Shared constants and state encodings for the serial boot loader.
// The header byte marks the start of a frame; everything else arriving in IDLE is ignored.
package mips_uart_loader_pkg;

    localparam logic [7:0] LDR_HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_CNT_HI,
        LDR_CNT_LO,
        LDR_DATA,
        LDR_CSUM,
        LDR_DONE,
        LDR_ERR
    } ldr_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // States in which a frame is open: timeouts and framing errors abort only here.
    function automatic logic frame_open(input ldr_state_t s);
        return (s == LDR_CNT_HI) || (s == LDR_CNT_LO) || (s == LDR_DATA) || (s == LDR_CSUM);
    endfunction

endpackage

// File: rtl/mips_uart_loader_if.sv
// RAM write port driven by the boot loader while it owns the memory.
interface mips_uart_loader_if;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_dout_o;
    logic [3:0]  mem_wren_o;

    modport master (output mem_addr_o, output mem_dout_o, output mem_wren_o);
    modport slave  (input  mem_addr_o, input  mem_dout_o, input  mem_wren_o);

endinterface

// File: rtl/mips_uart_loader_uart_rx_byte.sv
// 8N1 UART receiver: synchroniser, bit timer and shifter producing one byte per frame.
// byte_vld and frame_err are single-cycle pulses in the stop-bit sample cycle.
module uart_rx_byte
    import mips_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_rxd,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    logic            rxd_m, rxd_s, rxd_d;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    // Two flops against metastability plus one more for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m   <= 1'b1;
            rxd_s   <= 1'b1;
            rxd_d   <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            rxd_m   <= ser_rxd;
            rxd_s   <= rxd_m;
            rxd_d   <= rxd_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rxd_d && !rxd_s) state_d = RX_START;
            end
            RX_START: begin
                // A line back high at mid start bit was a glitch, not a frame.
                if (cnt_q == HALF_BIT) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte   = shift_q;
    assign byte_vld  = (state_q == RX_STOP) && (cnt_q == FULL_BIT) &&  rxd_s;
    assign frame_err = (state_q == RX_STOP) && (cnt_q == FULL_BIT) && !rxd_s;

endmodule

// File: rtl/mips_uart_loader.sv
// Serial boot loader: parses A5 | count | words | xor-checksum frames from the UART and
// writes the words into instruction RAM, holding the core in reset until a load succeeds.
module mips_uart_loader
    import mips_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MEM_WORDS    = 1024,
    parameter int TIMEOUT_BITS = 2000,
    parameter bit BOOT_HOLD    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ser_rxd,
    mips_uart_loader_if.master  mem,
    output logic                hold_core_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int AW = IW + 2;
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TO_CYCLES - 1);

    logic [7:0]  rx_byte;
    logic        byte_vld;
    logic        frame_err;

    ldr_state_t  state_q, state_d;
    logic [7:0]  cnt_hi_q;
    logic [15:0] word_cnt_q;
    logic [IW-1:0] word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] asm_q;
    logic [7:0]  csum_q;
    logic [TW-1:0] to_cnt_q;

    logic [15:0] n_word;
    logic        last_word;
    logic        timeout;
    logic [AW-1:0] word_addr;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ser_rxd  (ser_rxd),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .frame_err(frame_err)
    );

    assign n_word    = {cnt_hi_q, rx_byte};
    assign last_word = (16'(word_idx_q) == (word_cnt_q - 16'd1));
    assign timeout   = frame_open(state_q) && (to_cnt_q == TO_LIMIT);
    assign word_addr = {word_idx_q, 2'b00};

    always_comb begin
        state_d = state_q;
        case (state_q)
            LDR_IDLE:   if (byte_vld && rx_byte == LDR_HDR_BYTE) state_d = LDR_CNT_HI;
            LDR_CNT_HI: if (byte_vld) state_d = LDR_CNT_LO;
            LDR_CNT_LO: begin
                if (byte_vld) begin
                    if (n_word > 16'(MEM_WORDS)) state_d = LDR_ERR;
                    else if (n_word == 16'd0)    state_d = LDR_CSUM;
                    else                         state_d = LDR_DATA;
                end
            end
            LDR_DATA:   if (byte_vld && byte_idx_q == 2'd3 && last_word) state_d = LDR_CSUM;
            LDR_CSUM:   if (byte_vld) state_d = (rx_byte == csum_q) ? LDR_DONE : LDR_ERR;
            LDR_DONE:   state_d = LDR_IDLE;
            LDR_ERR:    state_d = LDR_IDLE;
            default:    state_d = LDR_IDLE;
        endcase
        if (frame_open(state_q) && (frame_err || timeout)) state_d = LDR_ERR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= LDR_IDLE;
            cnt_hi_q       <= '0;
            word_cnt_q     <= '0;
            word_idx_q     <= '0;
            byte_idx_q     <= '0;
            asm_q          <= '0;
            csum_q         <= '0;
            to_cnt_q       <= '0;
            mem.mem_addr_o <= '0;
            mem.mem_dout_o <= '0;
            mem.mem_wren_o <= '0;
            hold_core_o    <= BOOT_HOLD;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem.mem_wren_o <= '0;
            if (!frame_open(state_q) || byte_vld) to_cnt_q <= '0;
            else                                  to_cnt_q <= to_cnt_q + 1'b1;

            case (state_q)
                LDR_IDLE: begin
                    if (state_d == LDR_CNT_HI) begin
                        busy_o         <= 1'b1;
                        hold_core_o    <= 1'b1;
                        done_o         <= 1'b0;
                        err_o          <= 1'b0;
                        word_idx_q     <= '0;
                        byte_idx_q     <= '0;
                        csum_q         <= '0;
                        mem.mem_addr_o <= '0;
                    end
                end
                LDR_CNT_HI: if (byte_vld) begin
                    cnt_hi_q <= rx_byte;
                    csum_q   <= csum_q ^ rx_byte;
                end
                LDR_CNT_LO: if (byte_vld) begin
                    word_cnt_q <= n_word;
                    csum_q     <= csum_q ^ rx_byte;
                end
                LDR_DATA: if (byte_vld) begin
                    // Words arrive MSB first; the 4th byte completes and commits the word.
                    csum_q     <= csum_q ^ rx_byte;
                    asm_q      <= {asm_q[15:0], rx_byte};
                    byte_idx_q <= byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        mem.mem_wren_o <= 4'hF;
                        mem.mem_dout_o <= {asm_q, rx_byte};
                        mem.mem_addr_o <= 32'(word_addr);
                        word_idx_q     <= word_idx_q + 1'b1;
                    end
                end
                LDR_DONE: begin
                    done_o      <= 1'b1;
                    busy_o      <= 1'b0;
                    hold_core_o <= 1'b0;
                end
                // Core stays held: RAM may contain a partial image.
                LDR_ERR: begin
                    err_o  <= 1'b1;
                    busy_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_uart_loader.sv
// Directed bench for mips_uart_loader: good/bad frames, oversize count, timeout,
// glitch rejection, framing error and asynchronous reset with both BOOT_HOLD settings.
module tb_mips_uart_loader;

    localparam int CPB = 16;
    localparam int TOB = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;
    logic hold_a, busy_a, done_a, err_a;
    logic hold_b, busy_b, done_b, err_b;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic [3:0]  wr_en   [16];

    mips_uart_loader_if if_a ();
    mips_uart_loader_if if_b ();

    mips_uart_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(1024), .TIMEOUT_BITS(TOB), .BOOT_HOLD(1'b1)) dut_a (
        .clk(clk), .rst(rst), .ser_rxd(rxd), .mem(if_a),
        .hold_core_o(hold_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    mips_uart_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(1024), .TIMEOUT_BITS(TOB), .BOOT_HOLD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .ser_rxd(rxd), .mem(if_b),
        .hold_core_o(hold_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    always #5 clk = ~clk;

    // Each cycle with any write enable is logged once; a stretched pulse logs twice.
    always @(negedge clk) begin
        if (if_a.mem_wren_o != 4'h0) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = if_a.mem_addr_o;
                wr_data[wr_cnt] = if_a.mem_dout_o;
                wr_en[wr_cnt]   = if_a.mem_wren_o;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        rxd = stop_val;
        repeat (CPB) @(posedge clk);
        rxd = 1'b1;
        if (!stop_val) repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (if_a.mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr got=%h exp=%h", if_a.mem_addr_o, 32'h0); end
        n_cmp++; if (if_a.mem_dout_o !== 32'h0) begin n_bad++; $display("FAIL rst_dout got=%h exp=%h", if_a.mem_dout_o, 32'h0); end
        n_cmp++; if (if_a.mem_wren_o !== 4'h0) begin n_bad++; $display("FAIL rst_wren got=%h exp=%h", if_a.mem_wren_o, 4'h0); end
        n_cmp++; if (hold_a !== 1'b1) begin n_bad++; $display("FAIL rst_hold_a got=%b exp=1", hold_a); end
        n_cmp++; if (hold_b !== 1'b0) begin n_bad++; $display("FAIL rst_hold_b got=%b exp=0", hold_b); end
        n_cmp++; if ({busy_a, done_a, err_a} !== 3'b000) begin n_bad++; $display("FAIL rst_status got=%b exp=000", {busy_a, done_a, err_a}); end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({hold_a, busy_a, done_a, err_a} !== 4'b1000) begin n_bad++; $display("FAIL rst_post got=%b exp=1000", {hold_a, busy_a, done_a, err_a}); end
    endtask

    task automatic test_good_frame();
        int base;
        base = wr_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
        send_byte(8'h46, 1'b1);
        settle();
        n_cmp++; if (wr_cnt - base !== 2) begin n_bad++; $display("FAIL good_nwr got=%0d exp=2", wr_cnt - base); end
        n_cmp++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h11223344 || wr_en[base] !== 4'hF)
            begin n_bad++; $display("FAIL good_w0 got=%h/%h/%h exp=00000000/11223344/f", wr_addr[base], wr_data[base], wr_en[base]); end
        n_cmp++; if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'hAABBCCDD || wr_en[base+1] !== 4'hF)
            begin n_bad++; $display("FAIL good_w1 got=%h/%h/%h exp=00000004/aabbccdd/f", wr_addr[base+1], wr_data[base+1], wr_en[base+1]); end
        n_cmp++; if ({hold_a, busy_a, done_a, err_a} !== 4'b0010) begin n_bad++; $display("FAIL good_status got=%b exp=0010", {hold_a, busy_a, done_a, err_a}); end
    endtask

    task automatic test_bad_csum();
        int base;
        base = wr_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        n_cmp++; if ({hold_a, busy_a, done_a} !== 3'b110) begin n_bad++; $display("FAIL csum_hdr got=%b exp=110", {hold_a, busy_a, done_a}); end
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
        send_byte(8'h47, 1'b1);
        settle();
        n_cmp++; if (wr_cnt - base !== 2) begin n_bad++; $display("FAIL csum_nwr got=%0d exp=2", wr_cnt - base); end
        n_cmp++; if ({hold_a, busy_a, done_a, err_a} !== 4'b1001) begin n_bad++; $display("FAIL csum_status got=%b exp=1001", {hold_a, busy_a, done_a, err_a}); end
    endtask

    task automatic test_oversize();
        int base;
        base = wr_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h01, 1'b1);
        settle();
        n_cmp++; if ({hold_a, busy_a, done_a, err_a} !== 4'b1001) begin n_bad++; $display("FAIL over_status got=%b exp=1001", {hold_a, busy_a, done_a, err_a}); end
        n_cmp++; if (wr_cnt - base !== 0) begin n_bad++; $display("FAIL over_nwr got=%0d exp=0", wr_cnt - base); end
    endtask

    task automatic test_timeout();
        int base;
        base = wr_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
        settle();
        n_cmp++; if ({busy_a, err_a} !== 2'b10) begin n_bad++; $display("FAIL to_early got=%b exp=10", {busy_a, err_a}); end
        repeat (TOB * CPB - 100) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({busy_a, err_a} !== 2'b10) begin n_bad++; $display("FAIL to_before got=%b exp=10", {busy_a, err_a}); end
        repeat (150) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({hold_a, busy_a, err_a} !== 3'b101) begin n_bad++; $display("FAIL to_expired got=%b exp=101", {hold_a, busy_a, err_a}); end
        n_cmp++; if (wr_cnt - base !== 0) begin n_bad++; $display("FAIL to_nwr got=%0d exp=0", wr_cnt - base); end
        base = wr_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
        send_byte(8'h23, 1'b1);
        settle();
        n_cmp++; if (wr_cnt - base !== 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hDEADBEEF)
            begin n_bad++; $display("FAIL recov_wr got=%0d/%h/%h exp=1/00000000/deadbeef", wr_cnt - base, wr_addr[base], wr_data[base]); end
        n_cmp++; if ({hold_a, busy_a, done_a, err_a} !== 4'b0010) begin n_bad++; $display("FAIL recov_status got=%b exp=0010", {hold_a, busy_a, done_a, err_a}); end
    endtask

    task automatic test_glitch_framing();
        int base;
        base = wr_cnt;
        // A glitch mistaken for a start bit would swallow the header that follows it.
        rxd = 1'b0;
        repeat (5) @(posedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        send_byte(8'hA5, 1'b1);
        settle();
        n_cmp++; if ({hold_a, busy_a, done_a} !== 3'b110) begin n_bad++; $display("FAIL glitch_hdr got=%b exp=110", {hold_a, busy_a, done_a}); end
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        settle();
        n_cmp++; if ({hold_a, busy_a, done_a, err_a} !== 4'b1001) begin n_bad++; $display("FAIL frame_err got=%b exp=1001", {hold_a, busy_a, done_a, err_a}); end
        n_cmp++; if (wr_cnt - base !== 0) begin n_bad++; $display("FAIL frame_nwr got=%0d exp=0", wr_cnt - base); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        base = wr_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        settle();
        n_cmp++; if (wr_cnt - base !== 1 || busy_a !== 1'b1) begin n_bad++; $display("FAIL mid_pre got=%0d/%b exp=1/1", wr_cnt - base, busy_a); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (if_a.mem_addr_o !== 32'h0 || if_a.mem_dout_o !== 32'h0 || if_a.mem_wren_o !== 4'h0)
            begin n_bad++; $display("FAIL mid_rst_mem got=%h/%h/%h exp=0/0/0", if_a.mem_addr_o, if_a.mem_dout_o, if_a.mem_wren_o); end
        n_cmp++; if ({hold_a, busy_a, done_a, err_a, hold_b} !== 5'b10000) begin n_bad++; $display("FAIL mid_rst_status got=%b exp=10000", {hold_a, busy_a, done_a, err_a, hold_b}); end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({hold_a, busy_a, hold_b, busy_b} !== 4'b1000) begin n_bad++; $display("FAIL mid_post got=%b exp=1000", {hold_a, busy_a, hold_b, busy_b}); end
        send_byte(8'hA5, 1'b1);
        settle();
        n_cmp++; if ({hold_a, busy_a, hold_b, busy_b} !== 4'b1111) begin n_bad++; $display("FAIL hdr_hold got=%b exp=1111", {hold_a, busy_a, hold_b, busy_b}); end
        n_cmp++; if (wr_cnt - base !== 1) begin n_bad++; $display("FAIL mid_nwr got=%0d exp=1", wr_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_oversize();
        test_timeout();
        test_glitch_framing();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
